mgt_01_nonrestoring_divider: RTL and testbench
==============================================

Name: mgt_01_nonrestoring_divider

Overview:
- Multi-cycle unsigned integer divider. It performs the inverse operation of the team's sequential Booth multiplier and uses the same clock-enable and valid style.
- Feeds the FPU high-performance divide/sqrt path with mantissa quotients, and the M-extension DIVU/REMU path.
- Retires 2 quotient bits per cycle by chaining two radix-2 non-restoring steps, then applies one final remainder correction step.

Parameters:
- XLEN, 32, operand width; must be even and ≥ 4.
- ITER, XLEN/2, iterations in DIVIDE state; derived, do not override.

Ports:
- clk_i, input, 1, system clock.
- rst_n_i, input, 1, reset; asynchronous, active-low.
- clk_en_i, input, 1, clock enable; low freezes every register, including the FSM.
- start_i, input, 1, request a division; sampled only in IDLE with clk_en_i=1.
- dividend_i, input, XLEN, unsigned dividend; sampled with start_i.
- divisor_i, input, XLEN, unsigned divisor; sampled with start_i.
- quotient_o, output, XLEN, unsigned quotient.
- remainder_o, output, XLEN, unsigned remainder.
- divide_by_zero_o, output, 1, the latched divisor was 0; qualified by valid_o.
- busy_o, output, 1, FSM not in IDLE.
- valid_o, output, 1, one-cycle pulse; results are valid.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - FSM goes to IDLE.
  - Counter, partial remainder P (XLEN+1 bits, signed), quotient register Q, divisor register D, and the dbz flag are all cleared.
  - Every output reads 0.
- FSM states: IDLE, DIVIDE, RESTORE, VALID. Transitions occur only on clock edges where clk_en_i=1.
- IDLE:
  - On start_i=1, load P=0, Q=dividend_i, D={1'b0,divisor_i} and counter=0.
  - If divisor_i==0, go to VALID with dbz=1 and load Q=all-ones, P={1'b0,dividend_i}. This is the RISC-V convention.
  - Otherwise go to DIVIDE.
  - Without start_i, stay in IDLE.
- DIVIDE, one step (applied twice per cycle, chained combinationally):
  - Shift {P,Q} left by 1.
  - If the old P was ≥ 0, set P=P−D; else set P=P+D.
  - Set Q[0] to the inverse of the new P's sign bit.
  - The counter increments each cycle. When the counter reaches ITER−1, go to RESTORE.
- RESTORE:
  - If P<0, set P=P+D. Q is unchanged.
  - Go to VALID.
- VALID:
  - valid_o=1 for exactly one enabled cycle, then go to IDLE.
  - quotient_o=Q and remainder_o=P[XLEN−1:0].
- Latency: if start_i is accepted at enabled edge N, valid_o is high after enabled edge N+ITER+2. That is 18 cycles for XLEN=32. Divide-by-zero takes 1 cycle.
- Throughput: one operation per ITER+3 cycles. start_i can be accepted again in the IDLE cycle after VALID.
- Output hold: quotient_o, remainder_o and divide_by_zero_o hold their values from VALID until the next accepted start_i. busy_o=1 in DIVIDE, RESTORE and VALID.
- start_i while busy_o=1 is ignored; the operation in flight is not disturbed.
- clk_en_i=0 at any point: state, counter and data hold. valid_o stays high if stalled in VALID.
- Reset mid-operation aborts immediately. No valid_o pulse is produced.
- Arithmetic: all internal add/subtract operations are XLEN+1 bits wide.
  - Dividend < divisor gives Q=0 and R=dividend.
  - Dividend = divisor gives Q=1 and R=0.

Optional Feature:
- Macro: MGT01_DIV_STICKY_EN.
- Defined: adds output port sticky_o (1 bit).
  - sticky_o = |remainder_o, registered in RESTORE; for divide-by-zero it is set to |dividend.
  - It is qualified by valid_o and held like the other results. The FPU uses it for the round/sticky bit.
  - Reset value is 0.
- Undefined: the port and its logic are absent. Everything else is identical.

Test Plan:
- 100 / 7 → after 18 cycles valid_o=1, quotient_o=14, remainder_o=2, divide_by_zero_o=0, busy_o=0 the next cycle.
- 0xFFFFFFFF / 1 → Q=0xFFFFFFFF, R=0. Also 0xFFFFFFFF / 0xFFFFFFFF → Q=1, R=0.
- 5 / 9 → Q=0, R=5. Also 0 / 3 → Q=0, R=0.
- 1234 / 0 → valid_o 1 cycle after start, divide_by_zero_o=1, Q=0xFFFFFFFF, R=1234. With the feature enabled, sticky_o=1.
- 1000 / 3 with clk_en_i low for 5 cycles mid-DIVIDE → valid_o delayed by exactly 5 cycles, Q=333, R=1 (sticky_o=1 if enabled). A second start_i asserted while busy is ignored.
- Start 77 / 5, assert rst_n_i low at cycle 6 → all outputs 0 asynchronously and no valid_o. After release, start 77 / 5 → Q=15, R=2.

Source files
------------

// File: rtl/mgt_01_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// mgt_01_nonrestoring_divider
//
// Purpose:
//   Multi-cycle unsigned integer divider. Two radix-2 non-restoring steps
//   are chained in each DIVIDE cycle, so the divider retires 2 quotient bits
//   per cycle. A single RESTORE cycle then corrects a negative partial
//   remainder. A zero divisor skips the iteration and returns the RISC-V
//   result: quotient = all ones, remainder = dividend.
//
// Optional feature:
//   Define MGT01_DIV_STICKY_EN to add sticky_o. This output is the OR of the
//   final remainder bits, or the OR of the dividend bits for a divide by zero.
//
// Ports:
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset
//   clk_en_i         clock enable; low freezes every register
//   start_i          request a division (sampled only in IDLE)
//   dividend_i       unsigned dividend, XLEN bits
//   divisor_i        unsigned divisor, XLEN bits
//   quotient_o       unsigned quotient
//   remainder_o      unsigned remainder
//   divide_by_zero_o latched divisor was zero (qualified by valid_o)
//   sticky_o         |remainder (only with MGT01_DIV_STICKY_EN)
//   busy_o           FSM not in IDLE
//   valid_o          one-cycle result strobe
// -----------------------------------------------------------------------------
module mgt_01_nonrestoring_divider #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN / 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            divide_by_zero_o,
`ifdef MGT01_DIV_STICKY_EN
    output logic            sticky_o,
`endif
    output logic            busy_o,
    output logic            valid_o
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVIDE  = 2'd1,
        S_RESTORE = 2'd2,
        S_VALID   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   r_p;      // signed partial remainder (two's complement)
    logic [XLEN-1:0] r_q;
    logic [XLEN:0]   r_d;      // zero-extended divisor
    logic            r_dbz;
`ifdef MGT01_DIV_STICKY_EN
    logic            r_sticky;
`endif

    // -------------------------------------------------------------------------
    // Two chained non-restoring steps. Element 0 is the registered state and
    // element 2 is the value after both steps.
    // All arithmetic is XLEN+1 bits wide. The shifted value can exceed that
    // range. The result of the add/subtract always lies in [-D, D), and
    // modular wrap-around leaves that result exact.
    // -------------------------------------------------------------------------
    logic [XLEN:0]   w_p_chain [0:2];
    logic [XLEN-1:0] w_q_chain [0:2];

    assign w_p_chain[0] = r_p;
    assign w_q_chain[0] = r_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_step
            logic [XLEN:0] w_p_shift;
            assign w_p_shift = {w_p_chain[gi][XLEN-1:0], w_q_chain[gi][XLEN-1]};
            // The add/subtract choice follows the sign of P before the shift.
            assign w_p_chain[gi+1] = w_p_chain[gi][XLEN] ? (w_p_shift + r_d)
                                                         : (w_p_shift - r_d);
            assign w_q_chain[gi+1] = {w_q_chain[gi][XLEN-2:0], ~w_p_chain[gi+1][XLEN]};
        end
    endgenerate

    // Final correction: a negative remainder gets the divisor added back once.
    logic [XLEN:0] w_p_fix;
    assign w_p_fix = r_p[XLEN] ? (r_p + r_d) : r_p;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else if (clk_en_i) begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = (divisor_i == '0) ? S_VALID : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_RESTORE;
                end
            end
            S_RESTORE: w_state_next = S_VALID;
            S_VALID:   w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            S_IDLE:  busy_o = 1'b0;
            S_VALID: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
            end
            default: busy_o = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_dbz    <= 1'b0;
`ifdef MGT01_DIV_STICKY_EN
            r_sticky <= 1'b0;
`endif
        end else if (clk_en_i) begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt <= '0;
                        r_d   <= {1'b0, divisor_i};
                        if (divisor_i == '0) begin
                            r_dbz    <= 1'b1;
                            r_q      <= '1;
                            r_p      <= {1'b0, dividend_i};
`ifdef MGT01_DIV_STICKY_EN
                            r_sticky <= |dividend_i;
`endif
                        end else begin
                            r_dbz    <= 1'b0;
                            r_q      <= dividend_i;
                            r_p      <= '0;
`ifdef MGT01_DIV_STICKY_EN
                            r_sticky <= 1'b0;
`endif
                        end
                    end
                end
                S_DIVIDE: begin
                    r_p   <= w_p_chain[2];
                    r_q   <= w_q_chain[2];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_RESTORE: begin
                    r_p      <= w_p_fix;
`ifdef MGT01_DIV_STICKY_EN
                    r_sticky <= |w_p_fix[XLEN-1:0];
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient_o       = r_q;
    assign remainder_o      = r_p[XLEN-1:0];
    assign divide_by_zero_o = r_dbz;
`ifdef MGT01_DIV_STICKY_EN
    assign sticky_o         = r_sticky;
`endif

endmodule

// File: tb/tb_mgt_01_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// tb_mgt_01_nonrestoring_divider
//
// Self-checking bench for mgt_01_nonrestoring_divider. Each operation is
// compared with plain "/" and "%" arithmetic. A zero divisor is expected to
// give the RISC-V result. The bench also checks latency in cycles, a
// clock-enable stall, a start request while busy, and an abort by reset.
// -----------------------------------------------------------------------------
module tb_mgt_01_nonrestoring_divider;

    localparam int XLEN = 32;
    localparam int ITER = XLEN / 2;

    logic            clk_i;
    logic            rst_n_i;
    logic            clk_en_i;
    logic            start_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [XLEN-1:0] quotient_o;
    logic [XLEN-1:0] remainder_o;
    logic            divide_by_zero_o;
`ifdef MGT01_DIV_STICKY_EN
    logic            sticky_o;
`endif
    logic            busy_o;
    logic            valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    mgt_01_nonrestoring_divider #(.XLEN(XLEN)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .clk_en_i         (clk_en_i),
        .start_i          (start_i),
        .dividend_i       (dividend_i),
        .divisor_i        (divisor_i),
        .quotient_o       (quotient_o),
        .remainder_o      (remainder_o),
        .divide_by_zero_o (divide_by_zero_o),
`ifdef MGT01_DIV_STICKY_EN
        .sticky_o         (sticky_o),
`endif
        .busy_o           (busy_o),
        .valid_o          (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one division. The latency is the number of clock edges from the
    // edge that accepts start_i up to the point where valid_o is seen. The
    // edge that accepts start_i counts as the first edge.
    // stall_len: number of edges with clk_en_i low, starting after stall_at.
    // extra: hold start_i with other operands while busy; it must be ignored.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int stall_at, input int stall_len, input bit extra);
        logic [XLEN-1:0] eq;
        logic [XLEN-1:0] er;
        logic            edbz;
        int              exp_lat;
        int              cyc;
        if (b == 0) begin
            eq = '1; er = a; edbz = 1'b1; exp_lat = 1;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; exp_lat = ITER + 2;
        end
        exp_lat += stall_len;

        @(negedge clk_i);
        start_i = 1'b1; dividend_i = a; divisor_i = b;
        cyc = 0;
        while (!valid_o && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) begin
                if (extra) begin
                    dividend_i = ~a;
                    divisor_i  = 32'd1;
                end else begin
                    start_i = 1'b0;
                end
            end
            if (cyc == 4) start_i = 1'b0;
            if (cyc == 2 && !valid_o) check("busy_mid", {63'd0, busy_o}, 64'd1);
            if (stall_len > 0 && cyc == stall_at) clk_en_i = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len) clk_en_i = 1'b1;
        end
        start_i = 1'b0;
        check("latency",  64'(cyc), 64'(exp_lat));
        check("valid",    {63'd0, valid_o}, 64'd1);
        check("quotient", {32'd0, quotient_o}, {32'd0, eq});
        check("remainder",{32'd0, remainder_o}, {32'd0, er});
        check("dbz",      {63'd0, divide_by_zero_o}, {63'd0, edbz});
`ifdef MGT01_DIV_STICKY_EN
        check("sticky",   {63'd0, sticky_o}, {63'd0, (b == 0) ? (|a) : (|er)});
`endif
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                 a, b, quotient_o, remainder_o, divide_by_zero_o, cyc);
        @(negedge clk_i);
        check("valid_drop", {63'd0, valid_o}, 64'd0);
        check("busy_drop",  {63'd0, busy_o}, 64'd0);
        check("q_hold",     {32'd0, quotient_o}, {32'd0, eq});
    endtask

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        int              seen_valid;

        rst_n_i = 1'b0; clk_en_i = 1'b1; start_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_q",     {32'd0, quotient_o}, 64'd0);
        check("rst_r",     {32'd0, remainder_o}, 64'd0);
        check("rst_busy",  {63'd0, busy_o}, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_dbz",   {63'd0, divide_by_zero_o}, 64'd0);
        rst_n_i = 1'b1;

        // Directed cases.
        run_op(32'd100, 32'd7, 0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op(32'd5, 32'd9, 0, 0, 1'b0);
        run_op(32'd0, 32'd3, 0, 0, 1'b0);
        run_op(32'd1234, 32'd0, 0, 0, 1'b0);
        run_op(32'd1000, 32'd3, 5, 5, 1'b1);

        // Reset aborts an operation in flight.
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = 32'd77; divisor_i = 32'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check("abort_q",     {32'd0, quotient_o}, 64'd0);
        check("abort_r",     {32'd0, remainder_o}, 64'd0);
        check("abort_busy",  {63'd0, busy_o}, 64'd0);
        check("abort_valid", {63'd0, valid_o}, 64'd0);
        seen_valid = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (valid_o) seen_valid++;
        end
        rst_n_i = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (valid_o) seen_valid++;
        end
        check("abort_no_valid", 64'(seen_valid), 64'd0);
        run_op(32'd77, 32'd5, 0, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = ra >> $urandom_range(0, 31);
                3: ra = rb;
                default: ;
            endcase
            run_op(ra, rb, 0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
